// File: rtl/hazard_scoreboard_if.sv
// Decode-stage hazard/reservation bus: the issuing pipeline drives the master side,
// the scoreboard sits on the slave side and returns stall, bypass and SC status.
interface hazard_scoreboard_if #(
    parameter int AW     = 5,
    parameter int CW     = 3,
    parameter int ADDR_W = 32
) ();
    logic              issue_valid;
    logic              issue_we;
    logic [AW-1:0]     issue_waddr;
    logic [CW-1:0]     issue_lat;
    logic              flush;
    logic [AW-1:0]     rs_addr;
    logic              rs_used;
    logic [AW-1:0]     rt_addr;
    logic              rt_used;
    logic              stall;
    logic              rs_fwd;
    logic              rt_fwd;
    logic              ll_set;
    logic              sc_check;
    logic [ADDR_W-1:0] mem_addr;
    logic              st_snoop;
    logic [ADDR_W-1:0] st_addr;
    logic              sc_ok;

    modport master (
        output issue_valid, issue_we, issue_waddr, issue_lat, flush,
        output rs_addr, rs_used, rt_addr, rt_used,
        output ll_set, sc_check, mem_addr, st_snoop, st_addr,
        input  stall, rs_fwd, rt_fwd, sc_ok
    );

    modport slave (
        input  issue_valid, issue_we, issue_waddr, issue_lat, flush,
        input  rs_addr, rs_used, rt_addr, rt_used,
        input  ll_set, sc_check, mem_addr, st_snoop, st_addr,
        output stall, rs_fwd, rt_fwd, sc_ok
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard unit: per-register latency down-counters drive stall/bypass,
// plus the LL/SC reservation that snooped stores can break.
module hazard_scoreboard #(
    parameter int NREG    = 32,
    parameter int AW      = 5,
    parameter int MAX_LAT = 4,
    parameter int CW      = 3,
    parameter int ADDR_W  = 32
) (
    input logic                clk,
    input logic                rst,
    hazard_scoreboard_if.slave bus_if
);
    localparam logic [CW-1:0] LAT_ONE = CW'(1);
    localparam logic [CW-1:0] LAT_MAX = CW'(MAX_LAT);

    logic [CW-1:0]       cnt_q [NREG];
    logic [CW-1:0]       cnt_d [NREG];
    logic [CW-1:0]       lat_eff;
    logic [CW-1:0]       rs_cnt;
    logic [CW-1:0]       rt_cnt;
    logic [CW-1:0]       wr_cnt;
    logic                rs_live;
    logic                rt_live;
    logic                wr_live;
    logic                rs_haz;
    logic                rt_haz;
    logic                waw;
    logic                stall;
    logic                accept;

    logic                resv_v_q;
    logic                resv_v_d;
    logic [ADDR_W-1:2]   resv_a_q;
    logic [ADDR_W-1:2]   resv_a_d;
    logic [ADDR_W-1:2]   mem_word;
    logic [ADDR_W-1:2]   st_word;
    logic                sc_match;
    logic                unused_lsbs;

    // Out-of-range latencies are clamped rather than rejected.
    always_comb begin
        lat_eff = bus_if.issue_lat;
        if (bus_if.issue_lat == '0) begin
            lat_eff = LAT_ONE;
        end else if (bus_if.issue_lat > LAT_MAX) begin
            lat_eff = LAT_MAX;
        end
    end

    assign rs_cnt  = cnt_q[bus_if.rs_addr];
    assign rt_cnt  = cnt_q[bus_if.rt_addr];
    assign wr_cnt  = cnt_q[bus_if.issue_waddr];

    assign rs_live = bus_if.rs_used && (bus_if.rs_addr != '0);
    assign rt_live = bus_if.rt_used && (bus_if.rt_addr != '0);
    assign wr_live = bus_if.issue_we && (bus_if.issue_waddr != '0);

    assign rs_haz  = rs_live && (rs_cnt > LAT_ONE);
    assign rt_haz  = rt_live && (rt_cnt > LAT_ONE);
    // A younger write must not land before an older, slower one to the same register.
    assign waw     = wr_live && (wr_cnt > lat_eff);

    assign stall   = bus_if.issue_valid && !bus_if.flush && (rs_haz || rt_haz || waw);
    assign accept  = bus_if.issue_valid && !bus_if.flush && !stall;

    assign bus_if.stall  = stall;
    assign bus_if.rs_fwd = rs_live && (rs_cnt == LAT_ONE);
    assign bus_if.rt_fwd = rt_live && (rt_cnt == LAT_ONE);

    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = (cnt_q[r] != '0) ? (cnt_q[r] - LAT_ONE) : '0;
        end
        if (accept && wr_live) begin
            cnt_d[bus_if.issue_waddr] = lat_eff;
        end
        cnt_d[0] = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

    // Reservation tracks word addresses only; byte offsets never matter.
    assign mem_word    = bus_if.mem_addr[ADDR_W-1:2];
    assign st_word     = bus_if.st_addr[ADDR_W-1:2];
    assign unused_lsbs = ^{bus_if.mem_addr[1:0], bus_if.st_addr[1:0]};
    assign sc_match    = resv_v_q && (resv_a_q == mem_word);

    assign bus_if.sc_ok = accept && bus_if.sc_check && sc_match;

    // Priority order: snoop clear, then SC consume, then LL set (LL wins a same-cycle snoop).
    always_comb begin
        resv_v_d = resv_v_q;
        resv_a_d = resv_a_q;
        if (bus_if.st_snoop && (st_word == resv_a_q)) begin
            resv_v_d = 1'b0;
        end
        if (accept && bus_if.sc_check) begin
            resv_v_d = 1'b0;
        end
        if (accept && bus_if.ll_set) begin
            resv_v_d = 1'b1;
            resv_a_d = mem_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resv_v_q <= 1'b0;
            resv_a_q <= '0;
        end else begin
            resv_v_q <= resv_v_d;
            resv_a_q <= resv_a_d;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: each cycle's expected {stall, rs_fwd, rt_fwd, sc_ok} is queued with
// the stimulus and compared at the following falling edge.
module tb_hazard_scoreboard;
    typedef struct {
        string      tag;
        logic [3:0] val;
    } exp_t;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    exp_t sb_q[$];
    exp_t cur;

    hazard_scoreboard_if #(.AW(5), .CW(3), .ADDR_W(32)) bus ();

    hazard_scoreboard #(
        .NREG(32), .AW(5), .MAX_LAT(4), .CW(3), .ADDR_W(32)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus_if (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            cur = sb_q.pop_front();
            chk(cur.tag, {28'd0, bus.stall, bus.rs_fwd, bus.rt_fwd, bus.sc_ok}, {28'd0, cur.val});
        end
    end

    task automatic idle();
        bus.issue_valid = 1'b0;
        bus.issue_we    = 1'b0;
        bus.issue_waddr = '0;
        bus.issue_lat   = '0;
        bus.flush       = 1'b0;
        bus.rs_addr     = '0;
        bus.rs_used     = 1'b0;
        bus.rt_addr     = '0;
        bus.rt_used     = 1'b0;
        bus.ll_set      = 1'b0;
        bus.sc_check    = 1'b0;
        bus.mem_addr    = '0;
        bus.st_snoop    = 1'b0;
        bus.st_addr     = '0;
    endtask

    task automatic wr(input logic [4:0] a, input logic [2:0] lat);
        bus.issue_valid = 1'b1;
        bus.issue_we    = 1'b1;
        bus.issue_waddr = a;
        bus.issue_lat   = lat;
    endtask

    task automatic rd_s(input logic [4:0] a);
        bus.issue_valid = 1'b1;
        bus.rs_used     = 1'b1;
        bus.rs_addr     = a;
    endtask

    task automatic rd_t(input logic [4:0] a);
        bus.issue_valid = 1'b1;
        bus.rt_used     = 1'b1;
        bus.rt_addr     = a;
    endtask

    task automatic ll(input logic [31:0] addr);
        bus.issue_valid = 1'b1;
        bus.ll_set      = 1'b1;
        bus.mem_addr    = addr;
    endtask

    task automatic sc(input logic [31:0] addr);
        bus.issue_valid = 1'b1;
        bus.sc_check    = 1'b1;
        bus.mem_addr    = addr;
    endtask

    task automatic snoop(input logic [31:0] addr);
        bus.st_snoop = 1'b1;
        bus.st_addr  = addr;
    endtask

    // Expected bits: {stall, rs_fwd, rt_fwd, sc_ok}
    task automatic step(input string tag, input logic [3:0] exp);
        exp_t e;
        e.tag = tag;
        e.val = exp;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk  = 0;
        n_pass = 0;
        rst    = 1'b1;
        idle();
        @(posedge clk);
        #1;

        idle(); rd_s(5'd5); rd_t(5'd6); sc(32'h1000); step("rst_outputs", 4'b0000);
        rst = 1'b0;

        // load-use: one stall, then bypass
        idle(); wr(5'd5, 3'd2);   step("t1_lw", 4'b0000);
        idle(); rd_s(5'd5);       step("t1_stall", 4'b1000);
        idle(); rd_s(5'd5);       step("t1_fwd", 4'b0100);
        idle(); rd_s(5'd5);       step("t1_idle", 4'b0000);

        // four-cycle multiply feeding rt
        idle(); wr(5'd7, 3'd4);   step("t2_mul", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            idle(); rd_t(5'd7);   step("t2_stall", 4'b1000);
        end
        idle(); rd_t(5'd7);       step("t2_fwd", 4'b0010);
        idle(); rd_t(5'd7);       step("t2_idle", 4'b0000);

        // WAW: short write waits until the long one is one cycle out
        idle(); wr(5'd3, 3'd4);   step("t3_mul", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            idle(); wr(5'd3, 3'd1); step("t3_waw", 4'b1000);
        end
        idle(); wr(5'd3, 3'd1);   step("t3_accept", 4'b0000);
        idle(); rd_s(5'd3);       step("t3_newfwd", 4'b0100);
        idle(); rd_s(5'd3);       step("t3_idle", 4'b0000);

        // illegal latencies clamp to 1 and MAX_LAT
        idle(); wr(5'd10, 3'd0);  step("lat0_wr", 4'b0000);
        idle(); rd_s(5'd10);      step("lat0_fwd", 4'b0100);
        idle(); wr(5'd11, 3'd7);  step("lat7_wr", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            idle(); rd_t(5'd11);  step("lat7_stall", 4'b1000);
        end
        idle(); rd_t(5'd11);      step("lat7_fwd", 4'b0010);

        // register zero is never tracked
        idle(); wr(5'd0, 3'd3);   step("t4_wr0", 4'b0000);
        idle(); rd_s(5'd0); rd_t(5'd0); step("t4_rd0", 4'b0000);

        // LL/SC basics
        idle(); ll(32'h1000);     step("t5_ll", 4'b0000);
        idle(); sc(32'h1002);     step("t5_sc_ok", 4'b0001);
        idle(); sc(32'h1000);     step("t5_sc_again", 4'b0000);
        idle(); ll(32'h1000);     step("t5_ll2", 4'b0000);
        idle(); snoop(32'h1000);  step("t5_snoop", 4'b0000);
        idle(); sc(32'h1000);     step("t5_sc_snooped", 4'b0000);
        idle(); ll(32'h2000);     step("snoop_other_ll", 4'b0000);
        idle(); snoop(32'h2004);  step("snoop_other", 4'b0000);
        idle(); sc(32'h2000);     step("snoop_other_sc", 4'b0001);
        idle(); ll(32'h3000); snoop(32'h3000); step("ll_snoop_same", 4'b0000);
        idle(); sc(32'h3000);     step("ll_wins_sc", 4'b0001);
        idle(); ll(32'h4000);     step("sc_snoop_ll", 4'b0000);
        idle(); sc(32'h4000); snoop(32'h4000); step("sc_snoop_same", 4'b0001);
        idle(); sc(32'h4000);     step("sc_snoop_after", 4'b0000);

        // stalled SC neither succeeds nor consumes the reservation
        idle(); ll(32'h5000);     step("stsc_ll", 4'b0000);
        idle(); wr(5'd12, 3'd4);  step("stsc_mul", 4'b0000);
        for (int i = 0; i < 3; i++) begin
            idle(); sc(32'h5000); rd_s(5'd12); step("stsc_stall", 4'b1000);
        end
        idle(); sc(32'h5000); rd_s(5'd12); step("stsc_issue", 4'b0101);

        // flushed SC leaves the reservation alone
        idle(); ll(32'h6000);     step("flsc_ll", 4'b0000);
        idle(); sc(32'h6000); bus.flush = 1'b1; step("flsc_flush", 4'b0000);
        idle(); sc(32'h6000);     step("flsc_sc", 4'b0001);

        // reset mid-operation with r9 pending and a live reservation
        idle(); wr(5'd9, 3'd4);   step("t6_mul", 4'b0000);
        idle(); ll(32'h7000);     step("t6_ll", 4'b0000);
        rst = 1'b1;
        idle(); rd_s(5'd9); sc(32'h7000); step("t6_in_rst", 4'b0000);
        rst = 1'b0;
        idle(); rd_s(5'd9);       step("t6_r9", 4'b0000);
        idle(); sc(32'h7000);     step("t6_sc", 4'b0000);

        // flush over a hazard: no stall, nothing recorded
        idle(); wr(5'd13, 3'd4);  step("fl_mul", 4'b0000);
        idle(); rd_s(5'd13); wr(5'd14, 3'd2); ll(32'h8000); bus.flush = 1'b1;
        step("fl_haz", 4'b0000);
        idle(); rd_s(5'd14);      step("fl_no_wr", 4'b0000);
        idle(); sc(32'h8000);     step("fl_no_ll", 4'b0000);

        idle();
        @(negedge clk);
        chk("sb_drain", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
